layer_sequencer: RTL and testbench
==================================

# layer_sequencer

Inter-layer sequencer between two fully-parallel `nn_layer` instances. It collects the per-neuron results of the upstream layer into a capture buffer as each neuron's `out_valid` pulses. Once every neuron has reported, it replays the values one per cycle as the downstream layer's serial input stream. It also drives the `local_addr` that indexes the downstream weight memories, one cycle ahead of data, to cover their synchronous read.

## Interface

Parameters:
- `NUM_NEURONS`, default 128: upstream layer width, which is also the downstream input count. Must be ≥ 2.
- `DATA_WIDTH`, default 16: per-neuron value width.

Ports:
- `clk` input, 1: sole clock, rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `in_valids` input, `NUM_NEURONS`: upstream `out_valids`, one pulse per neuron per frame.
- `layer_in` input, `NUM_NEURONS*DATA_WIDTH`: upstream `layer_out`. Neuron i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `data_out` output, `DATA_WIDTH`: serial value to the downstream `data_in`.
- `data_valid` output, 1: drives the downstream `input_valid`.
- `local_addr` output, 32: downstream weight index, zero-extended.
- `busy` output, 1: high in STREAM and DRAIN.
- `frame_done` output, 1: single-cycle pulse on the last data beat.
- `overrun` output, 1: sticky error flag.

## Operation

States: COLLECT, STREAM, DRAIN.

COLLECT:
- When `in_valids[i]` is high, latch slice i into `buf[i]` and set `mask[i]`.
- Several bits may be high in the same cycle; all of them are captured.
- A repeat valid for a neuron whose mask bit is already set overwrites `buf[i]`. The mask is unchanged.
- When the mask would become all-ones (including the bits arriving this cycle), move to STREAM at that edge with `idx`=0.

STREAM:
- `local_addr`=`idx`. On each edge, `idx` increments.
- `data_out` and `data_valid` are registered from the previous cycle's `idx`: `data_out`=`buf[idx_prev]`, `data_valid`=1 from the second STREAM cycle on.
- When `idx`=`NUM_NEURONS-1`, go to DRAIN.

DRAIN:
- One cycle.
- `data_out`=`buf[NUM_NEURONS-1]`, `data_valid`=1, `frame_done`=1, `local_addr` holds `NUM_NEURONS-1`.
- Next state is COLLECT with the mask cleared.

Arithmetic and width rules:
- `idx` is `$clog2(NUM_NEURONS)` bits.
- `local_addr` is `idx` zero-extended to 32 bits.
- There is no arithmetic on data. Values pass bit-exact.

Boundary conditions:
- Any `in_valids` bit high during STREAM or DRAIN is ignored and sets `overrun`. The buffer is untouched. `overrun` clears only on `rst`.
- Valids arriving in the DRAIN cycle are also ignored; they are not carried into the next frame.
- On the edge DRAIN→COLLECT, valids are sampled normally into the freshly cleared mask, i.e. the first COLLECT cycle accepts them.
- Reset mid-frame abandons the frame. The buffer contents are don't-care, the mask is cleared, and no `frame_done` is issued.

## Timing

Reset values:
- State = COLLECT, `mask`=0, `idx`=0.
- `data_out`=0, `data_valid`=0, `local_addr`=0, `busy`=0, `frame_done`=0, `overrun`=0.

Latency:
- The edge that samples the completing valid is edge E.
- Cycle after E: `local_addr`=0, no `data_valid`.
- Cycle E+2: `data_valid` with `buf[0]`.
- Beat k (value `buf[k]`) appears one cycle after `local_addr`=k, aligned with the downstream weight memory's registered `weight_out` for address k.

Frame timing:
- `data_valid` is high for exactly `NUM_NEURONS` consecutive cycles.
- `frame_done` coincides with the last beat.
- `busy` is high for `NUM_NEURONS+1` cycles.

In COLLECT, `local_addr` holds 0, and `data_out` holds its last value with `data_valid`=0.

There is no backpressure; the downstream consumes every beat.

## Structure

- Shared package `nn_pkg` holds:
  - state encoding localparams `SEQ_COLLECT`, `SEQ_STREAM`, `SEQ_DRAIN`;
  - the address-to-data lead constant `WMEM_READ_LATENCY` = 1, also used by `Weight_Memory` users.
- One sub-module, `layer_capture_buffer`: the `NUM_NEURONS`×`DATA_WIDTH` register file with per-slot write enable, the mask, an all-ones detect, and a registered read port indexed by `idx`.
- The FSM, counter, and flags stay in `layer_sequencer`.

## Test plan

All scenarios use `NUM_NEURONS`=4, `DATA_WIDTH`=16.

1. Simultaneous completion: all four valids pulse in one cycle with values 0x0010, 0x0020, 0x0030, 0x0040. Required: `local_addr` reads 0,1,2,3 starting the next cycle; `data_out` reads 0x0010…0x0040 one cycle later; `frame_done` is high with 0x0040.
2. Staggered completion: valids in order 2, 0, 3, 1 on separate cycles. Required: no `data_valid` until after bit 1; the stream order is still 0..3 with the correct values.
3. Duplicate valid: neuron 1 reports 0x1111 then 0x2222 before the others. Required: beat 1 = 0x2222, `overrun`=0.
4. Overrun: pulse `in_valids[0]` with 0xDEAD during STREAM. Required: `overrun` goes to 1 and stays; the streamed values are unchanged; the next frame still collects normally.
5. Reset mid-STREAM after 2 beats. Required: all outputs return to reset values immediately and asynchronously; no `frame_done`; a new full frame streams correctly.
6. Back-to-back frames: the next frame's valids arrive in the first cycle after DRAIN. Required: they are accepted, `overrun`=0, and the second stream starts 2 cycles later.

Source files
------------

// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// nn_pkg
//   Shared definitions for the neural-network datapath blocks.
//   - Sequencer state encodings (COLLECT / STREAM / DRAIN).
//   - WMEM_READ_LATENCY: cycles between presenting an address to a
//     Weight_Memory and its registered weight_out. The sequencer leads
//     data by exactly this many cycles.
// Revision: 1.0 - initial release
// ============================================================================
package nn_pkg;

  localparam logic [1:0] SEQ_COLLECT = 2'd0;
  localparam logic [1:0] SEQ_STREAM  = 2'd1;
  localparam logic [1:0] SEQ_DRAIN   = 2'd2;

  localparam int WMEM_READ_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_COLLECT = SEQ_COLLECT,
    ST_STREAM  = SEQ_STREAM,
    ST_DRAIN   = SEQ_DRAIN
  } seq_state_e;

endpackage : nn_pkg
`default_nettype wire

// File: rtl/layer_capture_buffer.sv
`default_nettype none
// ============================================================================
// layer_capture_buffer
//   NUM_NEURONS x DATA_WIDTH register file that captures upstream neuron
//   results, plus the "has reported" mask and a registered read port.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset (mask, read reg)
//   wr_en_i      - per-slot write enable (one bit per neuron)
//   wr_data_i    - packed slot data, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   clr_i        - clear the mask (end of frame)
//   rd_en_i      - load the read register from slot rd_idx_i
//   rd_idx_i     - read index
//   full_next_o  - mask including this cycle's writes is all ones
//   rd_data_o    - registered read data (holds when rd_en_i is low)
// Revision: 1.0 - initial release
// ============================================================================
module layer_capture_buffer #(
  parameter int NUM_NEURONS = 128,
  parameter int DATA_WIDTH  = 16,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS-1:0]            wr_en_i,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] wr_data_i,
  input  logic                              clr_i,
  input  logic                              rd_en_i,
  input  logic [IDX_W-1:0]                  rd_idx_i,
  output logic                              full_next_o,
  output logic [DATA_WIDTH-1:0]             rd_data_o
);

  logic [DATA_WIDTH-1:0]  slot_q [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0]  rd_q;

  // Completion looks at the bits arriving this cycle too, so the frame can
  // switch to streaming on the same edge that captures the last value.
  always_comb begin
    full_next_o = &(mask_q | wr_en_i);
    mask_d      = clr_i ? '0 : (mask_q | wr_en_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mask_q <= '0;
    else     mask_q <= mask_d;
  end

  // Slot storage carries no reset: stale contents are never read because
  // streaming only starts once every slot of the frame has been written.
  for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_slot
    always_ff @(posedge clk) begin
      if (wr_en_i[i]) slot_q[i] <= wr_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rd_q <= '0;
    else if (rd_en_i) rd_q <= slot_q[rd_idx_i];
  end

  assign rd_data_o = rd_q;

endmodule : layer_capture_buffer
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// layer_sequencer
//   Collects per-neuron results of an upstream layer, then replays them one
//   per cycle as the downstream layer's serial input, driving local_addr one
//   cycle ahead of data to cover the weight memory's synchronous read.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   in_valids   - upstream per-neuron valid pulses
//   layer_in    - upstream packed results, neuron i at [i*DATA_WIDTH +: DATA_WIDTH]
//   data_out    - serial value to downstream data_in
//   data_valid  - downstream input_valid
//   local_addr  - downstream weight index (idx zero-extended)
//   busy        - high while streaming or draining
//   frame_done  - pulse on the last data beat
//   overrun     - sticky: a valid arrived while not collecting
// Revision: 1.0 - initial release
// ============================================================================
module layer_sequencer
  import nn_pkg::*;
#(
  parameter int NUM_NEURONS = 128,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS-1:0]            in_valids,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] layer_in,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              data_valid,
  output logic [31:0]                       local_addr,
  output logic                              busy,
  output logic                              frame_done,
  output logic                              overrun
);

  localparam int               IDX_W    = $clog2(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  seq_state_e             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   data_valid_q, data_valid_d;
  logic                   overrun_q, overrun_d;
  logic [NUM_NEURONS-1:0] wr_en;
  logic                   clr_mask;
  logic                   rd_en;
  logic                   full_next;

  layer_capture_buffer #(
    .NUM_NEURONS (NUM_NEURONS),
    .DATA_WIDTH  (DATA_WIDTH),
    .IDX_W       (IDX_W)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (wr_en),
    .wr_data_i   (layer_in),
    .clr_i       (clr_mask),
    .rd_en_i     (rd_en),
    .rd_idx_i    (idx_q),
    .full_next_o (full_next),
    .rd_data_o   (data_out)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wr_en        = '0;
    clr_mask     = 1'b0;
    rd_en        = 1'b0;
    // Data lags the address by one cycle: a beat is valid in the cycle after
    // its address was presented, i.e. whenever the previous cycle streamed.
    data_valid_d = (state_q == ST_STREAM);
    overrun_d    = overrun_q | ((state_q != ST_COLLECT) && (|in_valids));

    unique case (state_q)
      ST_COLLECT: begin
        wr_en = in_valids;
        if (full_next) begin
          state_d = ST_STREAM;
          idx_d   = '0;
        end
      end
      ST_STREAM: begin
        rd_en = 1'b1;
        // idx stops at the last slot so local_addr holds it through DRAIN.
        if (idx_q == LAST_IDX) state_d = ST_DRAIN;
        else                   idx_d   = idx_q + IDX_W'(1);
      end
      ST_DRAIN: begin
        clr_mask = 1'b1;
        state_d  = ST_COLLECT;
        idx_d    = '0;
      end
      default: begin
        state_d = ST_COLLECT;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_COLLECT;
      idx_q        <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_valid = data_valid_q;
  assign local_addr = 32'(idx_q);
  assign busy       = (state_q != ST_COLLECT);
  assign frame_done = (state_q == ST_DRAIN);
  assign overrun    = overrun_q;

endmodule : layer_sequencer
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// ============================================================================
// tb_layer_sequencer
//   Directed self-checking bench for layer_sequencer (4 neurons x 16 bits).
// Revision: 1.0 - initial release
// ============================================================================
module tb_layer_sequencer;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valids;
  logic [N*W-1:0] layer_in;
  logic [W-1:0]   data_out;
  logic           data_valid;
  logic [31:0]    local_addr;
  logic           busy;
  logic           frame_done;
  logic           overrun;

  int errors = 0;
  int checks = 0;

  layer_sequencer #(.NUM_NEURONS(N), .DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valids  (in_valids),
    .layer_in   (layer_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .local_addr (local_addr),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack(input logic [W-1:0] v0, v1, v2, v3);
    return {v3, v2, v1, v0};
  endfunction

  // Present valids/data for exactly one sampling edge.
  task automatic pulse(input logic [N-1:0] v, input logic [N*W-1:0] d);
    in_valids = v;
    layer_in  = d;
    tick();
    in_valids = '0;
  endtask

  // Called in the cycle after the completing edge. inj=1 injects a valid
  // during STREAM, inj=2 injects valids during DRAIN.
  task automatic expect_stream(input string tag, input logic [W-1:0] v0, v1, v2, v3,
                               input int inj, input logic ovr_end);
    logic [W-1:0] v [4];
    v = '{v0, v1, v2, v3};
    in_valids = '0;
    chk($sformatf("%s.e1_addr", tag), local_addr, 32'd0);
    chk($sformatf("%s.e1_valid", tag), {31'd0, data_valid}, 32'd0);
    chk($sformatf("%s.e1_busy", tag), {31'd0, busy}, 32'd1);
    if (inj == 1) begin
      in_valids = 4'b0001;
      layer_in  = pack(16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD);
    end
    for (int k = 1; k < 4; k++) begin
      tick();
      in_valids = '0;
      chk($sformatf("%s.addr%0d", tag, k), local_addr, k);
      chk($sformatf("%s.valid%0d", tag, k), {31'd0, data_valid}, 32'd1);
      chk($sformatf("%s.data%0d", tag, k - 1), {16'd0, data_out}, {16'd0, v[k-1]});
      chk($sformatf("%s.fdone%0d", tag, k), {31'd0, frame_done}, 32'd0);
      if (inj == 1 && k == 1) chk($sformatf("%s.ovr_set", tag), {31'd0, overrun}, 32'd1);
    end
    tick();
    chk($sformatf("%s.drain_addr", tag), local_addr, 32'd3);
    chk($sformatf("%s.drain_data", tag), {16'd0, data_out}, {16'd0, v[3]});
    chk($sformatf("%s.drain_valid", tag), {31'd0, data_valid}, 32'd1);
    chk($sformatf("%s.drain_fdone", tag), {31'd0, frame_done}, 32'd1);
    chk($sformatf("%s.drain_busy", tag), {31'd0, busy}, 32'd1);
    if (inj == 2) begin
      in_valids = 4'hF;
      layer_in  = pack(16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF);
    end
    tick();
    in_valids = '0;
    chk($sformatf("%s.post_valid", tag), {31'd0, data_valid}, 32'd0);
    chk($sformatf("%s.post_busy", tag), {31'd0, busy}, 32'd0);
    chk($sformatf("%s.post_fdone", tag), {31'd0, frame_done}, 32'd0);
    chk($sformatf("%s.post_addr", tag), local_addr, 32'd0);
    chk($sformatf("%s.post_hold", tag), {16'd0, data_out}, {16'd0, v[3]});
    chk($sformatf("%s.post_ovr", tag), {31'd0, overrun}, {31'd0, ovr_end});
  endtask

  initial begin
    rst       = 1'b1;
    in_valids = '0;
    layer_in  = '0;
    tick();
    tick();
    chk("rst.data", {16'd0, data_out}, 32'd0);
    chk("rst.valid", {31'd0, data_valid}, 32'd0);
    chk("rst.addr", local_addr, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.fdone", {31'd0, frame_done}, 32'd0);
    chk("rst.ovr", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    tick();

    // 1. simultaneous completion
    pulse(4'hF, pack(16'h0010, 16'h0020, 16'h0030, 16'h0040));
    expect_stream("simul", 16'h0010, 16'h0020, 16'h0030, 16'h0040, 0, 1'b0);

    // 2. staggered completion: order 2, 0, 3, 1
    pulse(4'b0100, pack(16'hFFFF, 16'hFFFF, 16'h0202, 16'hFFFF));
    chk("stag.busy_a", {31'd0, busy}, 32'd0);
    pulse(4'b0001, pack(16'h0200, 16'hFFFF, 16'hFFFF, 16'hFFFF));
    chk("stag.busy_b", {31'd0, busy}, 32'd0);
    pulse(4'b1000, pack(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0203));
    chk("stag.busy_c", {31'd0, busy}, 32'd0);
    chk("stag.valid_c", {31'd0, data_valid}, 32'd0);
    pulse(4'b0010, pack(16'hFFFF, 16'h0201, 16'hFFFF, 16'hFFFF));
    expect_stream("stag", 16'h0200, 16'h0201, 16'h0202, 16'h0203, 0, 1'b0);

    // 3. duplicate valid on neuron 1
    pulse(4'b0010, pack(16'h0000, 16'h1111, 16'h0000, 16'h0000));
    pulse(4'b0010, pack(16'h0000, 16'h2222, 16'h0000, 16'h0000));
    chk("dup.busy", {31'd0, busy}, 32'd0);
    pulse(4'b1101, pack(16'h0300, 16'h9999, 16'h0302, 16'h0303));
    expect_stream("dup", 16'h0300, 16'h2222, 16'h0302, 16'h0303, 0, 1'b0);

    // 4. overrun during STREAM, then a normal frame with the flag still set
    pulse(4'hF, pack(16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03));
    expect_stream("ovr", 16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03, 1, 1'b1);
    pulse(4'hF, pack(16'h0B00, 16'h0B01, 16'h0B02, 16'h0B03));
    expect_stream("ovr_next", 16'h0B00, 16'h0B01, 16'h0B02, 16'h0B03, 0, 1'b1);

    // 5. asynchronous reset after two beats
    pulse(4'hF, pack(16'h0C00, 16'h0C01, 16'h0C02, 16'h0C03));
    tick();
    tick();
    chk("rstmid.beat1", {16'd0, data_out}, 32'h0C01);
    #2 rst = 1'b1;
    #1;
    chk("rstmid.data", {16'd0, data_out}, 32'd0);
    chk("rstmid.valid", {31'd0, data_valid}, 32'd0);
    chk("rstmid.addr", local_addr, 32'd0);
    chk("rstmid.busy", {31'd0, busy}, 32'd0);
    chk("rstmid.fdone", {31'd0, frame_done}, 32'd0);
    chk("rstmid.ovr", {31'd0, overrun}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rstmid.fdone_after", {31'd0, frame_done}, 32'd0);
    // Mask must have been cleared: one valid alone must not complete.
    pulse(4'b0001, pack(16'h0D00, 16'h0000, 16'h0000, 16'h0000));
    chk("rstmid.mask_clr", {31'd0, busy}, 32'd0);
    pulse(4'b1110, pack(16'h0000, 16'h0D01, 16'h0D02, 16'h0D03));
    expect_stream("rstnew", 16'h0D00, 16'h0D01, 16'h0D02, 16'h0D03, 0, 1'b0);

    // 6. back-to-back: valids in the first cycle after DRAIN
    pulse(4'hF, pack(16'h0E00, 16'h0E01, 16'h0E02, 16'h0E03));
    expect_stream("b2b", 16'h0E00, 16'h0E01, 16'h0E02, 16'h0E03, 0, 1'b0);

    // Valids during DRAIN: flagged as overrun and not carried forward.
    pulse(4'hF, pack(16'h0F00, 16'h0F01, 16'h0F02, 16'h0F03));
    expect_stream("drainv", 16'h0F00, 16'h0F01, 16'h0F02, 16'h0F03, 2, 1'b1);
    tick();
    chk("drainv.not_carried", {31'd0, busy}, 32'd0);
    chk("drainv.hold", {16'd0, data_out}, 32'h0F03);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_layer_sequencer
`default_nettype wire
